sprite_palette_engine: RTL
==========================

# sprite_palette_engine

Parametrised, runtime-writable palette unit for the sprite/tank renderer. It holds NUM_PALETTES banks of 2^INDEX_W RGB entries in block RAM and maps a streamed (palette, index) pixel to 12-bit-style RGB through a 2-stage pipeline. It also flags transparent pixels and applies a frame-synchronous white "hit flash" effect. It sits between the sprite ROM address/index stage and the VGA colour mux.

## Interface
- NUM_PALETTES, 4: number of palette banks (1–16)
- INDEX_W, 4: colour index width; 2^INDEX_W entries per bank
- COLOR_W, 4: bits per colour channel
- TRANSPARENT_INDEX, 0: index treated as transparent
- FLASH_FRAMES, 8: frame_ticks per flash sequence (≥1)
- PAL_W (localparam): max(1, $clog2(NUM_PALETTES))

- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe for palette RAM
- wr_pal  in  PAL_W  bank to write
- wr_index  in  INDEX_W  entry to write
- wr_rgb  in  3*COLOR_W  {red, green, blue} write data
- pix_valid  in  1  lookup request valid
- pix_pal  in  PAL_W  bank select for lookup
- pix_index  in  INDEX_W  colour index for lookup
- frame_tick  in  1  one-cycle pulse per frame (vsync edge)
- flash_start  in  1  one-cycle pulse to start/restart flash
- out_valid  out  1  output pixel valid
- red, green, blue  out  COLOR_W each  looked-up colour
- out_transparent  out  1  pixel is transparent
- flash_active  out  1  flash FSM not IDLE

## Operation
- Palette RAM: NUM_PALETTES × 2^INDEX_W × 3*COLOR_W. Not cleared by Reset; power-up contents all zero.
- Writes: when wr_en=1 and wr_pal < NUM_PALETTES, entry is written at the clock edge. When wr_pal ≥ NUM_PALETTES, the write is silently ignored.
- Lookup pipeline:
  - S1 registers pix_valid, pix_pal and pix_index.
  - S2 reads RAM with the S1 address, then registers the colour, out_valid and out_transparent.
  - Bubbles (pix_valid=0) propagate as out_valid=0. Colour outputs hold their last value when out_valid=0.
- Transparency: out_transparent=1 when the S1 index == TRANSPARENT_INDEX. The colour output is still the RAM value.
- Out-of-range bank: if the S1 pal ≥ NUM_PALETTES, the output is RGB=0 and out_transparent=1.
- Flash FSM states:
  - IDLE: flash_start → ON, remaining=FLASH_FRAMES.
  - ON / OFF: on frame_tick, remaining -= 1. If remaining becomes 0 → IDLE; otherwise ON↔OFF toggle.
  - flash_start in ON/OFF restarts: → ON, remaining=FLASH_FRAMES.
  - flash_start and frame_tick in the same cycle: start wins, and the tick is not counted.
- Flash effect: if the FSM is ON in the cycle S2 registers, non-transparent valid pixels output RGB = all ones. Transparent and out-of-range pixels are unaffected.
- flash_active = (state != IDLE), registered.
- remaining is $clog2(FLASH_FRAMES+1) bits wide and never underflows.

## Timing
- Lookup latency is 2 cycles: a request at edge N produces out_valid at edge N+2. Throughput is 1 pixel/cycle.
- Read/write collision: S2 reads in the cycle after request capture.
  - A write committed at an edge before the S2 read edge is visible.
  - A write in the same cycle as the S2 read to the same address returns old data (read-before-write).
- Flash state changes take effect at the edge after flash_start/frame_tick. A pixel in S2 in that same cycle sees the old state.
- Reset values: out_valid=0, red/green/blue=0, out_transparent=0, flash_active=0, FSM=IDLE, remaining=0, S1 valid=0.
- Reset mid-stream drops all in-flight pixels. There is no out_valid for requests captured before Reset. RAM contents are preserved.

## Configuration
- PALETTE_FLASH_EN defined: flash FSM, counter and white override are present as above.
- PALETTE_FLASH_EN undefined:
  - FSM and counter are removed; flash_start and frame_tick are ignored.
  - flash_active is tied to 0.
  - Colours are always RAM values.
  - Pipeline latency is unchanged (2 cycles).

## Test plan
- Write bank 1 idx 5 = 12'hF91, then look up (1,5) → 2 cycles later out_valid=1, RGB=F,9,1, out_transparent=0.
- Back-to-back lookups (0,3), (0,0), bubble, (2,7) → outputs on consecutive cycles with one out_valid=0 gap. (0,0) yields out_transparent=1.
- Look up pix_pal=NUM_PALETTES-1+1 (with NUM_PALETTES=3, pal=3) → RGB=0, out_transparent=1. Write to pal=3 → no RAM entry changes.
- Old value 12'h111, then write 12'hABC to (0,4) in the same cycle as the S2 read of (0,4) → returns 12'h111; the next lookup returns 12'hABC.
- FLASH_FRAMES=4: flash_start, then 4 frame_ticks → state ON,OFF,ON,OFF,IDLE. Non-transparent pixels are FFF only during ON, and flash_active drops after the 4th tick. Restart mid-sequence and a start+tick collision reset the count to 4.
- Assert Reset with pixels in flight and the flash in ON → next cycle all outputs are 0 and flash_active=0. Post-reset lookup returns pre-reset RAM data.

Source files
------------

// File: rtl/sprite_palette_engine.sv
// Banked palette RAM with a 2-stage (palette, index) -> RGB lookup pipeline and transparency flag.
// Define PALETTE_FLASH_EN to add the frame-synchronous white hit-flash FSM.
module sprite_palette_engine #(
   parameter int unsigned NUM_PALETTES      = 4,
   parameter int unsigned INDEX_W           = 4,
   parameter int unsigned COLOR_W           = 4,
   parameter int unsigned TRANSPARENT_INDEX = 0,
   parameter int unsigned FLASH_FRAMES      = 8,
   localparam int unsigned PAL_W = (NUM_PALETTES > 1) ? $clog2(NUM_PALETTES) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [PAL_W-1:0]     wr_pal,
   input  logic [INDEX_W-1:0]   wr_index,
   input  logic [3*COLOR_W-1:0] wr_rgb,
   input  logic                 pix_valid,
   input  logic [PAL_W-1:0]     pix_pal,
   input  logic [INDEX_W-1:0]   pix_index,
   input  logic                 frame_tick,
   input  logic                 flash_start,
   output logic                 out_valid,
   output logic [COLOR_W-1:0]   red,
   output logic [COLOR_W-1:0]   green,
   output logic [COLOR_W-1:0]   blue,
   output logic                 out_transparent,
   output logic                 flash_active
);

   localparam int unsigned DEPTH = 2 ** INDEX_W;
   localparam int unsigned RGB_W = 3 * COLOR_W;
   localparam logic [PAL_W:0] NUM_PAL_C = (PAL_W + 1)'(NUM_PALETTES);
   localparam logic [INDEX_W-1:0] TRANSP_C = INDEX_W'(TRANSPARENT_INDEX);

   logic [RGB_W-1:0]   mem [NUM_PALETTES][DEPTH];
   logic               s1_valid;
   logic [PAL_W-1:0]   s1_pal;
   logic [INDEX_W-1:0] s1_index;
   logic               wr_ok;
   logic               s1_ok;
   logic               s1_transp;
   logic               flash_on;
   logic [RGB_W-1:0]   rd_rgb;
   logic [RGB_W-1:0]   pix_rgb;
   logic [RGB_W-1:0]   rgb_q;

   assign wr_ok = ({1'b0, wr_pal} < NUM_PAL_C);
   assign s1_ok = ({1'b0, s1_pal} < NUM_PAL_C);

   // RAM is deliberately outside the reset domain so contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en && wr_ok) begin
         mem[wr_pal][wr_index] <= wr_rgb;
      end
   end

   always_comb begin
      rd_rgb    = '0;
      pix_rgb   = '0;
      s1_transp = !s1_ok || (s1_index == TRANSP_C);
      if (s1_ok) begin
         rd_rgb  = mem[s1_pal][s1_index];
         pix_rgb = (flash_on && !s1_transp) ? '1 : rd_rgb;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid        <= 1'b0;
         s1_pal          <= '0;
         s1_index        <= '0;
         out_valid       <= 1'b0;
         out_transparent <= 1'b0;
         rgb_q           <= '0;
      end else begin
         s1_valid  <= pix_valid;
         s1_pal    <= pix_pal;
         s1_index  <= pix_index;
         out_valid <= s1_valid;
         // Colour and transparency hold through bubbles.
         if (s1_valid) begin
            rgb_q           <= pix_rgb;
            out_transparent <= s1_transp;
         end
      end
   end

   assign red   = rgb_q[3*COLOR_W-1:2*COLOR_W];
   assign green = rgb_q[2*COLOR_W-1:COLOR_W];
   assign blue  = rgb_q[COLOR_W-1:0];

`ifdef PALETTE_FLASH_EN
   localparam int unsigned REM_W = $clog2(FLASH_FRAMES + 1);

   typedef enum logic [1:0] {StIdle, StOn, StOff} flash_state_e;

   flash_state_e     state_q, state_d;
   logic [REM_W-1:0] rem_q, rem_d;
   logic             active_q;

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      // A start in the same cycle as a tick wins and swallows the tick.
      if (flash_start) begin
         state_d = StOn;
         rem_d   = REM_W'(FLASH_FRAMES);
      end else if (frame_tick && (state_q != StIdle)) begin
         if (rem_q <= REM_W'(1)) begin
            state_d = StIdle;
            rem_d   = '0;
         end else begin
            rem_d   = rem_q - REM_W'(1);
            state_d = (state_q == StOn) ? StOff : StOn;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         rem_q    <= '0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         active_q <= (state_d != StIdle);
      end
   end

   assign flash_on     = (state_q == StOn);
   assign flash_active = active_q;
`else
   logic unused_flash;

   assign unused_flash = flash_start ^ frame_tick;
   assign flash_on     = 1'b0;
   assign flash_active = 1'b0;
`endif

endmodule
